// File: rtl/watch_pkg.sv
// -----------------------------------------------------------------------------
// watch_pkg
// Shared definitions for the watch mode controller:
//   - mode_t      : display / control mode encoding (also driven on mode_out)
//   - sw_state_t  : stopwatch handshake state; the encoding is the output pair
//                   {sw_start_stop, sw_mode_in}, so the outputs come straight
//                   from the state flops
//   - CLR_TICKS / ALARM_TICKS defaults, stopwatch saturation hour
//   - helpers: counter width sizing, mode sequencing
// -----------------------------------------------------------------------------
package watch_pkg;

  typedef enum logic [1:0] {
    MODE_CLOCK     = 2'b00,
    MODE_STOPWATCH = 2'b01,
    MODE_TIMER     = 2'b10,
    MODE_INVALID   = 2'b11
  } mode_t;

  // Encoded as {start_stop, mode_in}.
  typedef enum logic [1:0] {
    SW_STOP = 2'b00,
    SW_CLR  = 2'b01,
    SW_RUN  = 2'b10
  } sw_state_t;

  localparam int         CLR_TICKS_DEFAULT   = 2;
  localparam int         ALARM_TICKS_DEFAULT = 30;
  localparam logic [4:0] SW_HOUR_SAT         = 5'd12;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // CLOCK -> STOPWATCH -> TIMER -> CLOCK; the unused code recovers to CLOCK.
  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_CLOCK:     return MODE_STOPWATCH;
      MODE_STOPWATCH: return MODE_TIMER;
      default:        return MODE_CLOCK;
    endcase
  endfunction

endpackage

// File: rtl/sw_ctrl.sv
// -----------------------------------------------------------------------------
// sw_ctrl
// Stopwatch handshake FSM. Runs independently of the displayed mode; the
// parent gates start/clear so they arrive only when they apply here.
// Ports:
//   clk, resetn            board clock, async active-low reset
//   tick_1hz               one-clk pulse per second (paces the clear hold)
//   start, clear           qualified one-clk button pulses
//   sw_hour                stopwatch hour; 12 means the stopwatch saturated
//   sw_start_stop          1 while running
//   sw_mode_in             1 while the clear request is held
// -----------------------------------------------------------------------------
module sw_ctrl
  import watch_pkg::*;
#(
  parameter int CLR_TICKS = CLR_TICKS_DEFAULT
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tick_1hz,
  input  logic       start,
  input  logic       clear,
  input  logic [4:0] sw_hour,
  output logic       sw_start_stop,
  output logic       sw_mode_in
);

  localparam int            CW       = cnt_width(CLR_TICKS);
  localparam logic [CW-1:0] CLR_LOAD = CW'(CLR_TICKS);

  sw_state_t     state;
  logic [CW-1:0] clr_cnt;
  logic          saturated;  // blocks start until a clear has completed

  // The state code is the output pair, so both outputs are flop outputs.
  assign {sw_start_stop, sw_mode_in} = state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= SW_STOP;
      clr_cnt   <= '0;
      saturated <= 1'b0;
    end else if (clear) begin
      // Entering from any state, or reloading while already clearing.
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state   <= SW_CLR;
      clr_cnt <= CLR_LOAD;
    end else begin
      case (state)
        SW_STOP: if (start && !saturated) state <= SW_RUN;
        SW_RUN: begin
          if (sw_hour == SW_HOUR_SAT) begin
            state     <= SW_STOP;
            saturated <= 1'b1;
          end else if (start) begin
            state <= SW_STOP;
          end
        end
        SW_CLR: begin
          // Leave one clk after the count reaches zero.
          if (clr_cnt == '0) begin
            state     <= SW_STOP;
            saturated <= 1'b0;
          end else if (tick_1hz) begin
            clr_cnt <= clr_cnt - CW'(1);
          end
        end
        default: state <= SW_STOP;
      endcase
    end
  end

endmodule

// File: rtl/mode_ctrl.sv
// -----------------------------------------------------------------------------
// mode_ctrl
// Top of the watch control slice: mode FSM, countdown-timer control, expiry
// alarm and registered display mux. The stopwatch handshake lives in sw_ctrl.
// Ports:
//   clk, resetn                       board clock, async active-low reset
//   tick_1hz                          one-clk pulse per second
//   btn_mode/btn_start/btn_clear      debounced one-clk button pulses
//   clk_*/sw_*/tmr_*                  time-of-day, stopwatch, timer values
//   tmr_expired                       timer at zero (level)
//   sw_start_stop, sw_mode_in         stopwatch control levels
//   tmr_run, tmr_clear                timer enable, one-clk timer clear
//   disp_hour/disp_min/disp_sec       registered display value
//   mode_out                          00 CLOCK, 01 STOPWATCH, 10 TIMER
//   alarm                             timer-expiry alarm
// -----------------------------------------------------------------------------
module mode_ctrl
  import watch_pkg::*;
#(
  parameter int CLR_TICKS   = CLR_TICKS_DEFAULT,
  parameter int ALARM_TICKS = ALARM_TICKS_DEFAULT
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic [4:0] clk_hour,
  input  logic [5:0] clk_min,
  input  logic [5:0] clk_sec,
  input  logic [4:0] sw_hour,
  input  logic [5:0] sw_min,
  input  logic [5:0] sw_sec,
  input  logic [4:0] tmr_hour,
  input  logic [5:0] tmr_min,
  input  logic [5:0] tmr_sec,
  input  logic       tmr_expired,
  output logic       sw_start_stop,
  output logic       sw_mode_in,
  output logic       tmr_run,
  output logic       tmr_clear,
  output logic [4:0] disp_hour,
  output logic [5:0] disp_min,
  output logic [5:0] disp_sec,
  output logic [1:0] mode_out,
  output logic       alarm
);

  localparam int            AW         = cnt_width(ALARM_TICKS);
  localparam logic [AW-1:0] ALARM_LOAD = AW'(ALARM_TICKS);

  mode_t         mode;
  logic          tmr_exp_q;
  logic [AW-1:0] alarm_cnt;

  logic btn_any;
  logic btn_live;     // buttons act normally only while no alarm is pending
  logic exp_rise;
  logic tmr_nonzero;
  logic sw_start;
  logic sw_clear;

  assign btn_any     = btn_mode | btn_start | btn_clear;
  assign btn_live    = ~alarm;
  assign exp_rise    = tmr_expired & ~tmr_exp_q;
  assign tmr_nonzero = |{tmr_hour, tmr_min, tmr_sec};
  assign mode_out    = mode;

  // Qualified on the current (pre-switch) mode.
  assign sw_start = btn_live & btn_start & (mode == MODE_STOPWATCH);
  assign sw_clear = btn_live & btn_clear & (mode == MODE_STOPWATCH);

  sw_ctrl #(
    .CLR_TICKS(CLR_TICKS)
  ) u_sw_ctrl (
    .clk          (clk),
    .resetn       (resetn),
    .tick_1hz     (tick_1hz),
    .start        (sw_start),
    .clear        (sw_clear),
    .sw_hour      (sw_hour),
    .sw_start_stop(sw_start_stop),
    .sw_mode_in   (sw_mode_in)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mode      <= MODE_CLOCK;
      tmr_run   <= 1'b0;
      tmr_clear <= 1'b0;
      alarm     <= 1'b0;
      alarm_cnt <= '0;
      tmr_exp_q <= 1'b0;
      disp_hour <= '0;
      disp_min  <= '0;
      disp_sec  <= '0;
    end else begin
      tmr_exp_q <= tmr_expired;
      // NOTE: default-then-override; the later non-blocking assignment wins.
      tmr_clear <= 1'b0;

      if ((btn_live && btn_mode) || mode == MODE_INVALID)
        mode <= next_mode(mode);

      if (btn_live && mode == MODE_TIMER) begin
        if (btn_clear) begin
          tmr_run   <= 1'b0;
          tmr_clear <= 1'b1;
        end else if (btn_start) begin
          if (tmr_run)
            tmr_run <= 1'b0;
          else if (!tmr_expired && tmr_nonzero)
            tmr_run <= 1'b1;
        end
      end

      // Expiry overrides any timer button action in the same clk.
      if (exp_rise) begin
        tmr_run   <= 1'b0;
        alarm     <= 1'b1;
        alarm_cnt <= ALARM_LOAD;
      end else if (alarm) begin
        if (btn_any) begin
          alarm     <= 1'b0;
          alarm_cnt <= '0;
        end else if (tick_1hz) begin
          alarm_cnt <= alarm_cnt - AW'(1);
          if (alarm_cnt <= AW'(1)) alarm <= 1'b0;
        end
      end

      case (mode)
        MODE_STOPWATCH: {disp_hour, disp_min, disp_sec} <= {sw_hour, sw_min, sw_sec};
        MODE_TIMER:     {disp_hour, disp_min, disp_sec} <= {tmr_hour, tmr_min, tmr_sec};
        default:        {disp_hour, disp_min, disp_sec} <= {clk_hour, clk_min, clk_sec};
      endcase
    end
  end

endmodule

// File: doc/mode_ctrl.md
MODE_CTRL -- requirements
Module: mode_ctrl

Interface
REQ-001 Parameter CLR_TICKS, default 2: tick_1hz pulses for which the stopwatch clear request is held.
REQ-002 Parameter ALARM_TICKS, default 30: tick_1hz pulses after which an unacknowledged alarm self-clears.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk (board clock, rising edge) and resetn.
REQ-004 Ports (name  direction  width  meaning):
- clk  in  1  board clock
- resetn  in  1  asynchronous active-low reset
- tick_1hz  in  1  one-clk pulse per second, aligned with the clk_1Hz edge
- btn_mode, btn_start, btn_clear  in  1 each  debounced one-clk button pulses
- clk_hour/clk_min/clk_sec  in  5/6/6  time-of-day value
- sw_hour/sw_min/sw_sec  in  5/6/6  stopwatch value
- tmr_hour/tmr_min/tmr_sec  in  5/6/6  countdown timer value
- tmr_expired  in  1  timer reached zero (level)
- sw_start_stop, sw_mode_in  out  1 each  stopwatch control levels
- tmr_run  out  1  timer count enable
- tmr_clear  out  1  one-clk timer clear pulse
- disp_hour/disp_min/disp_sec  out  5/6/6  value shown on the display
- mode_out  out  2  active mode: 00 CLOCK, 01 STOPWATCH, 10 TIMER
- alarm  out  1  timer-expiry alarm

Function
REQ-005 Mode FSM SHALL cycle CLOCK->STOPWATCH->TIMER->CLOCK on each btn_mode pulse; encoding 11 SHALL return to CLOCK on the next clk.
REQ-006 disp_* SHALL be registered copies of the selected source, 1 clk latency after a source or mode change.
REQ-007 btn_start and btn_clear SHALL act only on the function of the current mode; in CLOCK they are ignored.
REQ-008 Stopwatch FSM SHALL run regardless of the displayed mode:
- SW_STOP: outputs (start_stop, mode_in) = (0,0)
- SW_RUN: (1,0)
- SW_CLR: (0,1)
REQ-009 btn_start SHALL move SW_STOP to SW_RUN and SW_RUN to SW_STOP; in SW_CLR it is ignored.
REQ-010 btn_clear in any stopwatch state SHALL enter SW_CLR and load a tick counter with CLR_TICKS.
REQ-011 In SW_CLR the counter SHALL decrement on each tick_1hz and enter SW_STOP on the clk after it reaches 0; a btn_clear in SW_CLR reloads the counter.
REQ-012 sw_hour==12 (stopwatch saturated) in SW_RUN SHALL force SW_STOP; btn_start SHALL then be ignored until a clear completes.
REQ-013 In TIMER mode, btn_start SHALL toggle tmr_run, except that start is refused while tmr_expired=1 or all tmr_* fields are 0.
REQ-014 In TIMER mode, btn_clear SHALL drive tmr_run=0 and pulse tmr_clear for exactly one clk.
REQ-015 Rising edge of tmr_expired SHALL drive tmr_run=0 and alarm=1 on the next clk, in any mode.
REQ-016 While alarm=1:
- Any button pulse SHALL clear alarm and be consumed with no other effect.
- Otherwise alarm SHALL clear after ALARM_TICKS tick_1hz pulses.
REQ-017 Same-clk events SHALL resolve as follows:
- btn_clear beats btn_start.
- btn_start/btn_clear apply to the pre-switch mode when btn_mode is also asserted.
- Alarm consumption beats all other button handling.

Reset
REQ-018 While resetn=0:
- mode_out=00, stopwatch FSM in SW_STOP, tmr_run=0, tmr_clear=0, alarm=0, disp_*=0, and all counters 0.
- Reset SHALL take effect asynchronously; the first update occurs on the first clk edge after release.
REQ-019 Reset mid-SW_CLR or mid-alarm SHALL abandon the operation without emitting a tmr_clear pulse.

Structure
REQ-020 Shared package watch_pkg SHALL hold the mode encodings, the stopwatch state encodings, and the CLR_TICKS/ALARM_TICKS defaults.
REQ-021 The stopwatch handshake FSM with its tick counter SHALL be the sub-module sw_ctrl; the mode FSM, timer control, alarm and display mux stay in mode_ctrl.

Verification
REQ-022 Reset, then btn_mode x3 -> mode_out steps 01, 10, 00; disp_* follows the matching source 1 clk later.
REQ-023 STOPWATCH mode: btn_start, then btn_clear -> (start_stop,mode_in) = (1,0) then (0,1); held through 2 tick_1hz pulses, then (0,0).
REQ-024 STOPWATCH mode: sw_hour forced to 12 in SW_RUN -> SW_STOP next clk; a following btn_start leaves sw_start_stop=0.
REQ-025 TIMER mode, tmr_* = 0:0:05: btn_start -> tmr_run=1; tmr_expired rises -> tmr_run=0 and alarm=1; btn_mode pulse -> alarm=0 with mode unchanged.
REQ-026 TIMER mode: btn_start and btn_clear in the same clk -> tmr_clear is a 1-clk pulse and tmr_run=0.
REQ-027 Assert resetn=0 mid-SW_CLR -> all outputs 0 asynchronously; after release, the stopwatch FSM is in SW_STOP.
